bus_txn_queue: RTL and testbench

//  Ingress buffer directly upstream of the bus design block: accepts address/data

---
 rtl/bus_txn_pkg.sv | 29 ++
 rtl/bus_txn_mem.sv | 26 ++
 rtl/bus_txn_queue.sv | 128 ++++++++++++
 tb/tb_bus_txn_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_txn_pkg.sv
// Shared types and helpers for the bus transaction ingress queue.
// Address classes, default widths and the address classifier.
package bus_txn_pkg;

    typedef enum logic [1:0] {
        ATYPE_LOW  = 2'd0,
        ATYPE_MID  = 2'd1,
        ATYPE_HIGH = 2'd2
    } atype_e;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 32;

    function automatic atype_e classify(
        input logic [63:0] addr,
        input logic [63:0] lo,
        input logic [63:0] mid
    );
        atype_e t;
        t = ATYPE_HIGH;
        if (addr <= lo) begin
            t = ATYPE_LOW;
        end else if (addr <= mid) begin
            t = ATYPE_MID;
        end
        return t;
    endfunction

endpackage

// File: rtl/bus_txn_mem.sv
// Queue storage: DEPTH x W register array, one write port, one async read port.
// Storage is deliberately not reset; validity is tracked by the queue level.
module bus_txn_mem #(
    parameter int W     = 98,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_txn_queue.sv
// In-order ingress queue with address classification and per-class counters.
// Optional per-entry even parity when BUS_TXN_PARITY_EN is defined.
module bus_txn_queue
    import bus_txn_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int          DEPTH     = 8,
    parameter logic [63:0] LOW_LIMIT = 64'h0000_FFFF,
    parameter logic [63:0] MID_LIMIT = 64'h00FF_FFFF,
    parameter int          CNT_W     = 16,
    parameter int          LVL_W     = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_atype,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  cnt_low,
    output logic [CNT_W-1:0]  cnt_mid,
    output logic [CNT_W-1:0]  cnt_high
`ifdef BUS_TXN_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef BUS_TXN_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int EW = ADDR_W + DATA_W + 2 + PW;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [CNT_W-1:0] r_cnt_low;
    logic [CNT_W-1:0] r_cnt_mid;
    logic [CNT_W-1:0] r_cnt_high;

    logic             w_push;
    logic             w_pop;
    atype_e           w_atype;
    logic [EW-1:0]    w_wentry;
    logic [EW-1:0]    w_rentry;

    assign w_atype = classify(64'(in_addr), LOW_LIMIT, MID_LIMIT);

`ifdef BUS_TXN_PARITY_EN
    assign w_wentry = {^{in_addr, in_data}, w_atype, in_data, in_addr};
`else
    assign w_wentry = {w_atype, in_data, in_addr};
`endif

    // Acceptance depends only on registered state, never on out_ready.
    assign in_ready  = !rst && (r_level != LVL_W'(DEPTH));
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    bus_txn_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wentry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rentry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_cnt_low  <= '0;
            r_cnt_mid  <= '0;
            r_cnt_high <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
            // Counters saturate at all-ones.
            if (w_push && w_atype == ATYPE_LOW && r_cnt_low != '1) begin
                r_cnt_low <= r_cnt_low + CNT_W'(1);
            end
            if (w_push && w_atype == ATYPE_MID && r_cnt_mid != '1) begin
                r_cnt_mid <= r_cnt_mid + CNT_W'(1);
            end
            if (w_push && w_atype == ATYPE_HIGH && r_cnt_high != '1) begin
                r_cnt_high <= r_cnt_high + CNT_W'(1);
            end
        end
    end

    assign out_addr  = w_rentry[ADDR_W-1:0];
    assign out_data  = w_rentry[ADDR_W +: DATA_W];
    assign out_atype = w_rentry[ADDR_W+DATA_W +: 2];
    assign level     = r_level;
    assign cnt_low   = r_cnt_low;
    assign cnt_mid   = r_cnt_mid;
    assign cnt_high  = r_cnt_high;

`ifdef BUS_TXN_PARITY_EN
    assign out_parity = out_valid & w_rentry[EW-1];
`endif

endmodule

// File: tb/tb_bus_txn_queue.sv
// Scoreboard bench for bus_txn_queue; define BUS_TXN_PARITY_EN to cover parity.
module tb_bus_txn_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_addr;
    logic [31:0] out_data;
    logic [1:0]  out_atype;
    logic [3:0]  level;
    logic [15:0] cnt_low;
    logic [15:0] cnt_mid;
    logic [15:0] cnt_high;
`ifdef BUS_TXN_PARITY_EN
    logic        out_parity;
`endif

    bus_txn_queue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_atype (out_atype),
        .level     (level),
        .cnt_low   (cnt_low),
        .cnt_mid   (cnt_mid),
        .cnt_high  (cnt_high)
`ifdef BUS_TXN_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
        logic [1:0]  t;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_pop = 0;
    int   m_cnt[3] = '{0, 0, 0};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [1:0] cls(input logic [63:0] a);
        if (a <= 64'h0000_FFFF) return 2'd0;
        if (a <= 64'h00FF_FFFF) return 2'd1;
        return 2'd2;
    endfunction

    // Monitor: each handshake at the next posedge consumes the head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_addr", out_addr, e.a);
                chk("out_data", 64'(out_data), 64'(e.d));
                chk("out_atype", 64'(out_atype), 64'(e.t));
                n_pop++;
            end
        end
    end

    task automatic push_txn(input logic [63:0] a, input logic [31:0] d,
                            input logic [1:0] t);
        bit ok;
        ok = 0;
        in_addr = a;
        in_data = d;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                sb.push_back('{a: a, d: d, t: t});
                m_cnt[t]++;
                break;
            end
        end
        if (!ok) chk("push_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (level == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic chk_cnts(input string nm);
        chk({nm, "_cnt_low"}, 64'(cnt_low), 64'(m_cnt[0]));
        chk({nm, "_cnt_mid"}, 64'(cnt_mid), 64'(m_cnt[1]));
        chk({nm, "_cnt_high"}, 64'(cnt_high), 64'(m_cnt[2]));
    endtask

    initial begin
        int  p0;
        bit  done;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_addr = '0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Single push, 1-cycle latency, then pop.
        push_txn(64'h10, 32'hA5, 2'd0);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_level", 64'(level), 64'd1);
        chk("t1_cnt_low", 64'(cnt_low), 64'd1);
        drain();
        chk("t1_level_pop", 64'(level), 64'd0);

        // Fill to full; a held 9th request is not taken.
        for (int i = 0; i < 8; i++) begin
            push_txn(64'h100 + 64'(i), 32'hB000 + 32'(i), 2'd0);
        end
        chk("t2_level_full", 64'(level), 64'd8);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        in_addr = 64'h0200_0000;
        in_data = 32'hDEAD;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_level_hold", 64'(level), 64'd8);
        in_valid = 1'b0;

        // Full + pop + push same cycle: pop only.
        in_addr = 64'h0300_0000;
        in_data = 32'hC0DE;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_in_ready_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("t3_level_pop", 64'(level), 64'd7);
        chk("t3_in_ready_next", 64'(in_ready), 64'd1);
        @(negedge clk);
        if (in_ready) begin
            sb.push_back('{a: 64'h0300_0000, d: 32'hC0DE, t: 2'd2});
            m_cnt[2]++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t3_level_refill", 64'(level), 64'd8);
        drain();
        chk_cnts("t3");

        // Class boundaries.
        push_txn(64'h0000_FFFF, 32'h1, 2'd0);
        push_txn(64'h0001_0000, 32'h2, 2'd1);
        push_txn(64'h00FF_FFFF, 32'h3, 2'd1);
        push_txn(64'h0100_0000, 32'h4, 2'd2);
        drain();
        chk_cnts("t4");

        // Back-to-back stream with random backpressure.
        p0 = n_pop;
        done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [63:0] a;
                    a = 64'(i) * 64'h0013_7777 + 64'h5;
                    push_txn(a, 32'h5000 + 32'(i), cls(a));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        chk("t5_pops", 64'(n_pop - p0), 64'd20);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        chk_cnts("t5");

        // Reset mid-occupancy.
        for (int i = 0; i < 5; i++) begin
            push_txn(64'h0200_0000 + 64'(i), 32'h7000 + 32'(i), 2'd2);
        end
        chk("t6_level5", 64'(level), 64'd5);
        rst = 1'b1;
        sb.delete();
        m_cnt = '{0, 0, 0};
        #1;
        chk("t6_in_ready_rst", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk_cnts("t6");
`ifdef BUS_TXN_PARITY_EN
        chk("t6_parity_empty", 64'(out_parity), 64'd0);
        push_txn(64'h0, 32'h1, 2'd0);
        chk("t6_parity_one", 64'(out_parity), 64'd1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
